// File: rtl/pad_gpio_pkg.sv
// pad_gpio_ctrl shared types: controller state and counter-width helper.
// Optional debounce is enabled with the PAD_GPIO_DEBOUNCE_EN macro.
package pad_gpio_pkg;

    typedef enum logic [1:0] {
        ST_PWRUP_HOLD = 2'd0,
        ST_ACTIVE     = 2'd1,
        ST_SAFE       = 2'd2
    } state_e;

    localparam int SYNC_MIN = 2;
    localparam int DEB_MIN  = 1;

    // Bits needed to hold 0..n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n < 1) return 1;
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pad_gpio_if.sv
// Core-side bundle of pad_gpio_ctrl: output request, input events, safe handshake.
// Debounce of the input path is selected by PAD_GPIO_DEBOUNCE_EN.
interface pad_gpio_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] out_en;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             ready;
    logic             safe_req;
    logic             safe_ack;

    modport master (
        output out_data, out_en, safe_req,
        input  in_data, rise, fall, ready, safe_ack
    );

    modport slave (
        input  out_data, out_en, safe_req,
        output in_data, rise, fall, ready, safe_ack
    );
endinterface

// File: rtl/pad_in_sync.sv
// Single-bit pad input synchroniser with optional debounce filter.
// The debounce counter is built only when PAD_GPIO_DEBOUNCE_EN is defined.
module pad_in_sync
    import pad_gpio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic i_pad,
    output logic o_data
);

    localparam int NS = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;

    logic [NS-1:0] r_sync;
    logic          w_sync;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[NS-2:0], i_pad};
        end
    end

    assign w_sync = r_sync[NS-1];

`ifdef PAD_GPIO_DEBOUNCE_EN
    localparam int ND = (DEBOUNCE_CYCLES < DEB_MIN) ? DEB_MIN : DEBOUNCE_CYCLES;
    localparam int DW = cnt_width(ND);

    logic [DW-1:0] r_cnt;
    logic          r_q;

    // Accept a new level only after ND consecutive differing samples.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt <= '0;
            r_q   <= 1'b0;
        end else if (w_sync != r_q) begin
            if (r_cnt == DW'(ND - 1)) begin
                r_q   <= w_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_data = r_q;
`else
    assign o_data = w_sync;
`endif

endmodule

// File: rtl/pad_gpio_ctrl.sv
// Core-side GPIO pad controller: power-up hold, safe-state handshake, input edges.
// Define PAD_GPIO_DEBOUNCE_EN to add per-bit input debounce.
module pad_gpio_ctrl
    import pad_gpio_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int PWRUP_CYCLES    = 64,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    pad_gpio_if.slave        core,
    output logic [WIDTH-1:0] PAD_O,
    output logic [WIDTH-1:0] PAD_OE,
    input  logic [WIDTH-1:0] PAD_I
);

    localparam int             CW       = cnt_width(PWRUP_CYCLES);
    localparam logic [CW-1:0]  CNT_INIT = CW'(PWRUP_CYCLES);

    state_e           r_state;
    state_e           w_next;
    logic [CW-1:0]    r_cnt;
    logic             w_ready;
    logic             w_safe_ack;
    logic             w_hold;

    logic [WIDTH-1:0] r_pad_o;
    logic [WIDTH-1:0] r_pad_oe;
    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_PWRUP_HOLD;
            r_cnt   <= CNT_INIT;
        end else begin
            r_state <= w_next;
            if (r_state == ST_PWRUP_HOLD && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_ready    = 1'b0;
        w_safe_ack = 1'b0;
        w_hold     = 1'b0;
        unique case (r_state)
            ST_PWRUP_HOLD: begin
                w_hold = 1'b1;
                if (r_cnt == '0) begin
                    w_next = core.safe_req ? ST_SAFE : ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                w_ready = 1'b1;
                if (core.safe_req) w_next = ST_SAFE;
            end
            ST_SAFE: begin
                w_safe_ack = 1'b1;
                if (!core.safe_req) w_next = ST_ACTIVE;
            end
            default: w_next = ST_PWRUP_HOLD;
        endcase
    end

    // Enables drop on the very edge that enters SAFE; data is left as it was.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pad_o  <= '0;
            r_pad_oe <= '0;
        end else if (w_next == ST_SAFE) begin
            r_pad_oe <= '0;
        end else if (r_state == ST_ACTIVE) begin
            r_pad_o  <= core.out_data;
            r_pad_oe <= core.out_en;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_in
        pad_in_sync #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_sync (
            .CLK    (CLK),
            .RESET  (RESET),
            .i_pad  (PAD_I[i]),
            .o_data (w_in[i])
        );
    end

    // History follows in_data during hold so the exit sees no stale edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_prev <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_prev <= w_in;
            r_rise <= w_hold ? '0 : (w_in & ~r_prev);
            r_fall <= w_hold ? '0 : (~w_in & r_prev);
        end
    end

    assign PAD_O         = r_pad_o;
    assign PAD_OE        = r_pad_oe;
    assign core.in_data  = w_in;
    assign core.rise     = r_rise;
    assign core.fall     = r_fall;
    assign core.ready    = w_ready;
    assign core.safe_ack = w_safe_ack;

endmodule

// File: tb/tb_pad_gpio_ctrl.sv
// Directed bench for pad_gpio_ctrl (PWRUP_CYCLES=64 and a PWRUP_CYCLES=0 copy).
// Debounce checks are compiled in when PAD_GPIO_DEBOUNCE_EN is defined.
module tb_pad_gpio_ctrl;

    localparam int W = 16;
`ifdef PAD_GPIO_DEBOUNCE_EN
    localparam int IN_LAT = 6;
`else
    localparam int IN_LAT = 2;
`endif

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic         rst0 = 1'b1;
    logic [W-1:0] pad_o, pad_oe, pad_i;
    logic [W-1:0] pad_o0, pad_oe0, pad_i0;
    int           n_tests = 0;
    int           n_fail  = 0;

    pad_gpio_if #(.WIDTH(W)) bus ();
    pad_gpio_if #(.WIDTH(W)) bus0 ();

    always #5 clk = ~clk;

    pad_gpio_ctrl #(
        .WIDTH(W), .SYNC_STAGES(2), .PWRUP_CYCLES(64), .DEBOUNCE_CYCLES(4)
    ) u_dut (
        .CLK(clk), .RESET(rst), .core(bus),
        .PAD_O(pad_o), .PAD_OE(pad_oe), .PAD_I(pad_i)
    );

    pad_gpio_ctrl #(
        .WIDTH(W), .SYNC_STAGES(2), .PWRUP_CYCLES(0), .DEBOUNCE_CYCLES(4)
    ) u_dut0 (
        .CLK(clk), .RESET(rst0), .core(bus0),
        .PAD_O(pad_o0), .PAD_OE(pad_oe0), .PAD_I(pad_i0)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        n_tests++;
        if (pad_oe !== 16'h0000) begin
            n_fail++; $display("FAIL reset_oe got %h want 0000", pad_oe);
        end
        n_tests++;
        if (pad_o !== 16'h0000) begin
            n_fail++; $display("FAIL reset_o got %h want 0000", pad_o);
        end
        n_tests++;
        if ({bus.in_data, bus.rise, bus.fall} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_in got %h/%h/%h want 0",
                     bus.in_data, bus.rise, bus.fall);
        end
        n_tests++;
        if ({bus.ready, bus.safe_ack} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_hs got %b%b want 00", bus.ready, bus.safe_ack);
        end
        rst = 1'b0;
    endtask

    task automatic test_pwrup();
        int bad = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (pad_oe !== 16'h0000 || bus.ready !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL pwrup_hold got %0d bad cycles want 0", bad);
        end
        tick();
        n_tests++;
        if (bus.ready !== 1'b1 || pad_oe !== 16'h0000) begin
            n_fail++;
            $display("FAIL pwrup_exit got ready=%b oe=%h want 1/0000",
                     bus.ready, pad_oe);
        end
        tick();
        n_tests++;
        if (pad_oe !== 16'hFFFF) begin
            n_fail++; $display("FAIL pwrup_oe got %h want ffff", pad_oe);
        end
    endtask

    task automatic test_out_latency();
        bus.out_data = 16'h0000;
        tick();
        bus.out_data = 16'hA5A5;
        bus.out_en   = 16'h00F0;
        n_tests++;
        if (pad_o !== 16'h0000) begin
            n_fail++; $display("FAIL lat_early got %h want 0000", pad_o);
        end
        tick();
        n_tests++;
        if (pad_o !== 16'hA5A5 || pad_oe !== 16'h00F0) begin
            n_fail++;
            $display("FAIL lat_1cyc got %h/%h want a5a5/00f0", pad_o, pad_oe);
        end
        bus.out_data = 16'h5A5A;
        bus.out_en   = 16'hFFFF;
        tick();
        n_tests++;
        if (pad_o !== 16'h5A5A || pad_oe !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL lat_next got %h/%h want 5a5a/ffff", pad_o, pad_oe);
        end
    endtask

    task automatic test_input_edges();
        int bad = 0;
        pad_i = 16'h0008;
        for (int i = 0; i < IN_LAT - 1; i++) begin
            tick();
            if (bus.in_data !== 16'h0000) bad++;
        end
        tick();
        n_tests++;
        if (bad != 0 || bus.in_data !== 16'h0008 || bus.rise !== 16'h0) begin
            n_fail++;
            $display("FAIL in_rise_lat got in=%h rise=%h early=%0d want 0008/0000/0",
                     bus.in_data, bus.rise, bad);
        end
        tick();
        n_tests++;
        if (bus.rise !== 16'h0008 || bus.fall !== 16'h0000) begin
            n_fail++;
            $display("FAIL rise_pulse got %h/%h want 0008/0000", bus.rise, bus.fall);
        end
        tick();
        n_tests++;
        if (bus.rise !== 16'h0000) begin
            n_fail++; $display("FAIL rise_single got %h want 0000", bus.rise);
        end
        pad_i = 16'h0000;
        tick(IN_LAT + 1);
        n_tests++;
        if (bus.fall !== 16'h0008 || bus.rise !== 16'h0000) begin
            n_fail++;
            $display("FAIL fall_pulse got %h/%h want 0008/0000", bus.fall, bus.rise);
        end
        tick();
        n_tests++;
        if (bus.fall !== 16'h0000) begin
            n_fail++; $display("FAIL fall_single got %h want 0000", bus.fall);
        end
        pad_i = 16'h8101;
        tick(IN_LAT + 1);
        n_tests++;
        if (bus.rise !== 16'h8101) begin
            n_fail++; $display("FAIL rise_multi got %h want 8101", bus.rise);
        end
        pad_i = 16'h0000;
        tick(IN_LAT + 3);
    endtask

    task automatic test_safe();
        bus.out_en   = 16'hFFFF;
        bus.out_data = 16'h1234;
        tick();
        bus.safe_req = 1'b1;
        bus.out_data = 16'hBEEF;
        tick();
        n_tests++;
        if (pad_oe !== 16'h0000 || bus.safe_ack !== 1'b1 || bus.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL safe_enter got oe=%h ack=%b rdy=%b want 0000/1/0",
                     pad_oe, bus.safe_ack, bus.ready);
        end
        n_tests++;
        if (pad_o !== 16'h1234) begin
            n_fail++; $display("FAIL safe_hold_o got %h want 1234", pad_o);
        end
        tick(3);
        n_tests++;
        if (pad_oe !== 16'h0000 || bus.safe_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL safe_stay got oe=%h ack=%b want 0000/1", pad_oe, bus.safe_ack);
        end
        bus.safe_req = 1'b0;
        tick();
        n_tests++;
        if (bus.safe_ack !== 1'b0 || bus.ready !== 1'b1 || pad_oe !== 16'h0000) begin
            n_fail++;
            $display("FAIL safe_exit got ack=%b rdy=%b oe=%h want 0/1/0000",
                     bus.safe_ack, bus.ready, pad_oe);
        end
        tick();
        n_tests++;
        if (pad_oe !== 16'hFFFF || pad_o !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL safe_resume got %h/%h want beef/ffff", pad_o, pad_oe);
        end
    endtask

`ifdef PAD_GPIO_DEBOUNCE_EN
    task automatic test_debounce();
        int bad   = 0;
        int rises = 0;
        pad_i = 16'h0001;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i == 2) pad_i = 16'h0000;
            if (bus.in_data[0] !== 1'b0 || bus.rise[0] !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL deb_glitch got %0d bad cycles want 0", bad);
        end
        bad = 0;
        pad_i = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.in_data[0] !== 1'b0) bad++;
        end
        tick();
        pad_i = 16'h0000;
        n_tests++;
        if (bad != 0 || bus.in_data[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL deb_accept got in=%b early=%0d want 1/0", bus.in_data[0], bad);
        end
        for (int i = 0; i < 14; i++) begin
            tick();
            if (bus.rise[0] === 1'b1) rises++;
        end
        n_tests++;
        if (rises != 1) begin
            n_fail++; $display("FAIL deb_rise got %0d pulses want 1", rises);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int bad = 0;
        bus.out_en   = 16'hFFFF;
        bus.out_data = 16'hC3C3;
        tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if (pad_oe !== 16'h0000 || bus.ready !== 1'b0 || pad_o !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_reset got oe=%h o=%h rdy=%b want 0000/0000/0",
                     pad_oe, pad_o, bus.ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (pad_oe !== 16'h0000 || bus.ready !== 1'b0 || bus.safe_ack !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL mid_reload got %0d bad cycles want 0", bad);
        end
        bus.safe_req = 1'b1;
        tick();
        n_tests++;
        if (bus.safe_ack !== 1'b1 || bus.ready !== 1'b0 || pad_oe !== 16'h0000) begin
            n_fail++;
            $display("FAIL sim_safe got ack=%b rdy=%b oe=%h want 1/0/0000",
                     bus.safe_ack, bus.ready, pad_oe);
        end
        bus.safe_req = 1'b0;
        tick(2);
        n_tests++;
        if (pad_oe !== 16'hFFFF) begin
            n_fail++; $display("FAIL sim_resume got %h want ffff", pad_oe);
        end
    endtask

    task automatic test_zero_pwrup();
        int bad = 0;
        rst0 = 1'b1;
        bus0.safe_req = 1'b1;
        tick();
        rst0 = 1'b0;
        tick();
        n_tests++;
        if (bus0.safe_ack !== 1'b1 || bus0.ready !== 1'b0 || pad_oe0 !== 16'h0000) begin
            n_fail++;
            $display("FAIL zero_safe got ack=%b rdy=%b oe=%h want 1/0/0000",
                     bus0.safe_ack, bus0.ready, pad_oe0);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pad_oe0 !== 16'h0000) bad++;
        end
        bus0.safe_req = 1'b0;
        tick();
        if (pad_oe0 !== 16'h0000) bad++;
        n_tests++;
        if (bad != 0 || bus0.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_exit got rdy=%b bad=%0d want 1/0", bus0.ready, bad);
        end
        tick();
        n_tests++;
        if (pad_oe0 !== 16'hFFFF) begin
            n_fail++; $display("FAIL zero_oe got %h want ffff", pad_oe0);
        end
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        tick();
        n_tests++;
        if (bus0.ready !== 1'b1 || bus0.safe_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_active got rdy=%b ack=%b want 1/0",
                     bus0.ready, bus0.safe_ack);
        end
    endtask

    initial begin
        pad_i         = '0;
        pad_i0        = '0;
        bus.out_data  = '0;
        bus.out_en    = 16'hFFFF;
        bus.safe_req  = 1'b0;
        bus0.out_data = 16'h00FF;
        bus0.out_en   = 16'hFFFF;
        bus0.safe_req = 1'b0;
        test_reset();
        test_pwrup();
        test_out_latency();
        test_input_edges();
        test_safe();
`ifdef PAD_GPIO_DEBOUNCE_EN
        test_debounce();
`endif
        test_reset_mid();
        test_zero_pwrup();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
